// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl: in-order retirement sequencer for the reorder buffer.
// Each cycle it looks at the EXT_COUNT head slots and decides how many retire.
// It drives ROB consume, register-file writes and store commit.
// After a mispredicted branch and its delay slot retire, it raises flush
// and then holds retirement off for FLUSH_CYCLES dead cycles.
module rob_commit_ctrl #(
  parameter int DEPTH        = 16,
  parameter int EXT_COUNT    = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int DEPTHLOG2    = $clog2(DEPTH),
  parameter int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DEPTHLOG2-1:0]      rob_ext_ptr,
  input  logic [DEPTHLOG2:0]        rob_used_count,
  input  logic [EXT_COUNT-1:0]      slot_valid,
  input  logic [EXT_COUNT-1:0]      slot_dest_valid,
  input  logic [5*EXT_COUNT-1:0]    slot_dest_reg,
  input  logic [32*EXT_COUNT-1:0]   slot_result,
  input  logic [EXT_COUNT-1:0]      slot_is_store,
  input  logic [EXT_COUNT-1:0]      slot_mispredict,
  input  logic                      store_ready,
  output logic                      consume,
  output logic [EXTCOUNTLOG2-1:0]   consume_count,
  output logic [EXT_COUNT-1:0]      rf_we,
  output logic [5*EXT_COUNT-1:0]    rf_waddr,
  output logic [32*EXT_COUNT-1:0]   rf_wdata,
  output logic                      store_commit,
  output logic                      flush,
  output logic [DEPTHLOG2-1:0]      flush_idx,
  output logic                      in_flush,
  output logic [31:0]               retired_total,
  output logic [15:0]               flush_total
);

  // n ranges 0..EXT_COUNT, so it needs one bit more than consume_count.
  localparam int NW    = EXTCOUNTLOG2 + 1;
  localparam int WAITW = ($clog2(FLUSH_CYCLES) > 3) ? $clog2(FLUSH_CYCLES) : 3;

  typedef enum logic {
    RUN,
    FLUSH_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [WAITW-1:0]       wait_q, wait_d;
  logic [31:0]            retired_q;
  logic [15:0]            flushes_q;

  logic [EXT_COUNT-1:0]   lane_ok;
  logic [EXT_COUNT-1:0]   retire_mask;
  logic [NW-1:0]          n;
  logic                   has_store;
  logic                   do_flush;
  logic                   stop;
  logic                   store_seen;
  logic                   pair_store_ok;

  // Count leading retirable lanes, applying the store and mispredict cut-offs.
  always_comb begin
    n             = '0;
    has_store     = 1'b0;
    do_flush      = 1'b0;
    stop          = 1'b0;
    store_seen    = 1'b0;
    lane_ok       = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      lane_ok[i] = (i < int'(rob_used_count)) && slot_valid[i];
    end
    pair_store_ok = !(slot_is_store[0] && slot_is_store[1]) &&
                    (store_ready || !(slot_is_store[0] || slot_is_store[1]));
    if (state_q == RUN) begin
      if (slot_mispredict[0]) begin
        // The branch only leaves together with its delay slot.
        if (lane_ok[0] && lane_ok[1] && pair_store_ok) begin
          n         = NW'(2);
          do_flush  = 1'b1;
          has_store = slot_is_store[0] | slot_is_store[1];
        end
      end else begin
        for (int i = 0; i < EXT_COUNT; i++) begin
          if (!stop) begin
            if (!lane_ok[i] || slot_mispredict[i]) begin
              stop = 1'b1;
            end else if (slot_is_store[i] && (store_seen || !store_ready)) begin
              stop = 1'b1;
            end else begin
              n = n + NW'(1);
              if (slot_is_store[i]) begin
                store_seen = 1'b1;
                has_store  = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // Turn the retire count into a per-lane mask.
  always_comb begin
    retire_mask = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      retire_mask[i] = (i < int'(n));
    end
  end

  // Next-state logic: enter the wait after a flush, count down, then resume.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        if (do_flush) begin
          state_d = FLUSH_WAIT;
          wait_d  = WAITW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH_WAIT: begin
        if (wait_q == '0) begin
          state_d = RUN;
        end else begin
          wait_d = wait_q - WAITW'(1);
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Retired-instruction and flush statistics; both wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
      flushes_q <= '0;
    end else begin
      if (n != '0) begin
        retired_q <= retired_q + 32'(n);
      end
      if (do_flush) begin
        flushes_q <= flushes_q + 16'd1;
      end
    end
  end

  // Outputs are zero-latency and all held low while reset is asserted.
  always_comb begin
    consume       = !reset && (n != '0);
    consume_count = (reset || n == '0) ? '0 : EXTCOUNTLOG2'(n - NW'(1));
    rf_we         = reset ? '0 : (retire_mask & slot_dest_valid & ~slot_is_store);
    rf_waddr      = reset ? '0 : slot_dest_reg;
    rf_wdata      = reset ? '0 : slot_result;
    store_commit  = !reset && has_store;
    flush         = !reset && do_flush;
    flush_idx     = (!reset && do_flush) ? rob_ext_ptr : '0;
    in_flush      = !reset && (state_q == FLUSH_WAIT);
    retired_total = reset ? '0 : retired_q;
    flush_total   = reset ? '0 : flushes_q;
  end

endmodule
